// File: rtl/arrow_pkg.sv
// Shared types and constants for the arrow pattern player.
//   ARROW_LANES : default number of arrow lanes per chart step
//   arrow_t     : one chart step (one bit per lane)
//   seq_state_t : playback state (IDLE, RUN, PAUSED, DONE)
package arrow_pkg;

  localparam int unsigned ARROW_LANES = 4;

  typedef logic [ARROW_LANES-1:0] arrow_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/beat_counter.sv
// Free-running beat period counter.
//   Clk    : system clock
//   Reset  : synchronous active-high reset
//   clear  : restart the period from 0 (wins over enable)
//   enable : advance the count this cycle
//   tick   : combinational, high on the terminal-count cycle while enabled
module beat_counter #(
  parameter int unsigned BEAT_CYCLES = 50_000_000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = $clog2(BEAT_CYCLES);

  logic [CW-1:0] count;
  logic          at_term;

  // Equality against the last value keeps the count in range for any period.
  assign at_term = (count == CW'(BEAT_CYCLES - 1));
  assign tick    = enable && at_term;

  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= at_term ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/arrow_sequencer.sv
// Beat-driven arrow pattern player: plays a writable chart one step per beat.
//   Clk, Reset       : clock, synchronous active-high reset
//   wr_en/addr/data  : chart write port (any state, read-before-write)
//   length           : steps to play (1..DEPTH), latched on accepted start
//   loop_en          : wrap to step 0 after the last step
//   start, pause     : start/restart request, playback freeze
//   arrows, index    : step pattern on display and its chart address
//   beat             : one-cycle strobe when arrows/index update
//   busy, done       : playing (RUN/PAUSED), finished (DONE)
module arrow_sequencer
  import arrow_pkg::*;
#(
  parameter int unsigned LANES       = ARROW_LANES,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned BEAT_CYCLES = 50_000_000
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [LANES-1:0]           wr_data,
  input  logic [$clog2(DEPTH+1)-1:0] length,
  input  logic                       loop_en,
  input  logic                       start,
  input  logic                       pause,
  output logic [LANES-1:0]           arrows,
  output logic                       beat,
  output logic [$clog2(DEPTH)-1:0]   index,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [LANES-1:0] mem [DEPTH];
  seq_state_t       state;
  logic [AW-1:0]    ptr;
  logic [LW-1:0]    len_q;
  logic             start_ok;
  logic             active;
  logic             last;
  logic             tick;

  assign start_ok = start && (length != '0) && (length <= LW'(DEPTH));
  assign active   = (state == RUN) || (state == PAUSED);
  assign last     = (LW'(ptr) == len_q - LW'(1));

  // PAUSED with pause low counts like RUN, so the frozen count resumes at once.
  beat_counter #(
    .BEAT_CYCLES(BEAT_CYCLES)
  ) u_beat_counter (
    .Clk    (Clk),
    .Reset  (Reset),
    .clear  (start_ok),
    .enable (active && !pause),
    .tick   (tick)
  );

  // Chart storage; not reset.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Playback FSM with registered outputs; priority start > pause > beat.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      arrows <= '0;
      beat   <= 1'b0;
      index  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      ptr    <= '0;
      len_q  <= '0;
    end else begin
      beat <= 1'b0;
      if (start_ok) begin
        state <= RUN;
        len_q <= length;
        ptr   <= '0;
        busy  <= 1'b1;
        done  <= 1'b0;
      end else if (active) begin
        if (pause) begin
          state <= PAUSED;
        end else if (tick) begin
          arrows <= mem[ptr];
          index  <= ptr;
          beat   <= 1'b1;
          if (last) begin
            ptr <= '0;
            if (loop_en) begin
              state <= RUN;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            ptr   <= ptr + AW'(1);
            state <= RUN;
          end
        end else begin
          state <= RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_arrow_sequencer.sv
// Directed bench for arrow_sequencer with a 4-cycle beat and a 4-step chart.
module tb_arrow_sequencer;
  import arrow_pkg::*;

  localparam int unsigned LANES = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned BC    = 4;

  logic       Clk;
  logic       Reset;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [3:0] wr_data;
  logic [4:0] length;
  logic       loop_en;
  logic       start;
  logic       pause;
  arrow_t     arrows;
  logic       beat;
  logic [3:0] index;
  logic       busy;
  logic       done;

  int vecs = 0;
  int errs = 0;

  int exp_arr[5] = '{1, 2, 4, 1, 2};
  int exp_idx[5] = '{0, 1, 2, 0, 1};

  arrow_sequencer #(
    .LANES      (LANES),
    .DEPTH      (DEPTH),
    .BEAT_CYCLES(BC)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .length  (length),
    .loop_en (loop_en),
    .start   (start),
    .pause   (pause),
    .arrows  (arrows),
    .beat    (beat),
    .index   (index),
    .busy    (busy),
    .done    (done)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    length = '0; loop_en = 1'b0; start = 1'b0; pause = 1'b0;
    step();
    step();
    chk("rst_arrows", 32'(arrows), 0);
    chk("rst_beat",   32'(beat),   0);
    chk("rst_index",  32'(index),  0);
    chk("rst_busy",   32'(busy),   0);
    chk("rst_done",   32'(done),   0);
    Reset = 1'b0;

    // Chart {0001, 0010, 0100, 1000}
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 4'(1 << i);
      step();
    end
    wr_en = 1'b0;

    // One-shot play of 4 steps
    length = 5'd4; loop_en = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_busy0", 32'(busy), 1);
    chk("t1_beat0", 32'(beat), 0);
    for (int n = 1; n <= 16; n++) begin
      step();
      if (n % 4 == 0) begin
        chk("t1_beat",   32'(beat),   1);
        chk("t1_arrows", 32'(arrows), 1 << (n / 4 - 1));
        chk("t1_index",  32'(index),  n / 4 - 1);
      end else begin
        chk("t1_nobeat", 32'(beat), 0);
        if (n < 4) chk("t1_hold", 32'(arrows), 0);
      end
    end
    chk("t1_done", 32'(done), 1);
    chk("t1_busy", 32'(busy), 0);
    for (int n = 0; n < 6; n++) begin
      step();
      chk("t1_after_beat", 32'(beat), 0);
    end
    chk("t1_after_arrows", 32'(arrows), 8);
    chk("t1_after_done",   32'(done),   1);

    // Looping play of 3 steps
    length = 5'd3; loop_en = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (n % 4 == 0) begin
        chk("t2_beat",   32'(beat),   1);
        chk("t2_arrows", 32'(arrows), exp_arr[n / 4 - 1]);
        chk("t2_index",  32'(index),  exp_idx[n / 4 - 1]);
        chk("t2_done",   32'(done),   0);
      end else begin
        chk("t2_nobeat", 32'(beat), 0);
      end
    end

    // Pause sampled high on the 2nd..6th edges after the beat: next beat 9 edges later
    step();
    pause = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step();
      chk("t3_pbeat",   32'(beat),   0);
      chk("t3_parrows", 32'(arrows), 2);
      chk("t3_pbusy",   32'(busy),   1);
    end
    pause = 1'b0;
    step();
    chk("t3_nobeat1", 32'(beat), 0);
    step();
    chk("t3_nobeat2", 32'(beat), 0);
    step();
    chk("t3_beat",   32'(beat),   1);
    chk("t3_arrows", 32'(arrows), 4);
    chk("t3_index",  32'(index),  2);

    // Pause landing on the terminal-count cycle
    step();
    step();
    step();
    pause = 1'b1;
    step();
    chk("t4_tc_beat",   32'(beat),   0);
    chk("t4_tc_arrows", 32'(arrows), 4);
    step();
    chk("t4_hold_beat", 32'(beat), 0);
    pause = 1'b0;
    step();
    chk("t4_beat",   32'(beat),   1);
    chk("t4_arrows", 32'(arrows), 1);
    chk("t4_index",  32'(index),  0);
    for (int n = 1; n <= 4; n++) begin
      step();
      if (n == 4) begin
        chk("t4_next_beat",   32'(beat),   1);
        chk("t4_next_arrows", 32'(arrows), 2);
      end else begin
        chk("t4_next_nobeat", 32'(beat), 0);
      end
    end

    // Restart with length 2 after the third step of a 4-step run
    length = 5'd4; loop_en = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (n % 4 == 0) begin
        chk("t5_beat",   32'(beat),   1);
        chk("t5_arrows", 32'(arrows), 1 << (n / 4 - 1));
      end else begin
        chk("t5_nobeat", 32'(beat), 0);
      end
    end
    step();
    length = 5'd2; start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_rs_beat",   32'(beat),   0);
    chk("t5_rs_arrows", 32'(arrows), 4);
    chk("t5_rs_busy",   32'(busy),   1);
    for (int n = 0; n < 3; n++) begin
      step();
      chk("t5_rs_hold_beat",   32'(beat),   0);
      chk("t5_rs_hold_arrows", 32'(arrows), 4);
    end
    step();
    chk("t5_b1_beat",   32'(beat),   1);
    chk("t5_b1_arrows", 32'(arrows), 1);
    chk("t5_b1_index",  32'(index),  0);
    chk("t5_b1_done",   32'(done),   0);
    for (int n = 0; n < 3; n++) begin
      step();
      chk("t5_gap_beat", 32'(beat), 0);
    end
    step();
    chk("t5_b2_beat",   32'(beat),   1);
    chk("t5_b2_arrows", 32'(arrows), 2);
    chk("t5_b2_index",  32'(index),  1);
    chk("t5_b2_done",   32'(done),   1);
    chk("t5_b2_busy",   32'(busy),   0);

    // Reset mid-run, then ignored starts
    length = 5'd4; start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < 5; n++) step();
    chk("t6_run_busy", 32'(busy), 1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("t6_rst_arrows", 32'(arrows), 0);
    chk("t6_rst_beat",   32'(beat),   0);
    chk("t6_rst_index",  32'(index),  0);
    chk("t6_rst_busy",   32'(busy),   0);
    chk("t6_rst_done",   32'(done),   0);
    length = 5'd0; start = 1'b1;
    step();
    chk("t6_len0_busy", 32'(busy), 0);
    length = 5'd17;
    step();
    chk("t6_len17_busy", 32'(busy), 0);
    start = 1'b0;
    for (int n = 0; n < 5; n++) begin
      step();
      chk("t6_idle_beat", 32'(beat), 0);
    end

    // New data at addr 0 plays; a same-edge write returns the old word
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 4'b1010;
    step();
    wr_en = 1'b0;
    length = 5'd1; start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      if (n == 4) begin
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 4'b0110;
      end
      step();
      wr_en = 1'b0;
      if (n == 4) begin
        chk("t6_new_beat",   32'(beat),   1);
        chk("t6_new_arrows", 32'(arrows), 'ha);
        chk("t6_new_index",  32'(index),  0);
        chk("t6_new_done",   32'(done),   1);
      end else begin
        chk("t6_new_nobeat", 32'(beat), 0);
      end
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 0; n < 4; n++) step();
    chk("t6_rbw_beat",   32'(beat),   1);
    chk("t6_rbw_arrows", 32'(arrows), 6);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
